// File: rtl/data_cache_write_back_buffer_pkg.sv
// Shared types for the data-cache write-back buffer.
// The write-back record is also used by DataCache when it evicts a line.
package data_cache_write_back_buffer_pkg;

  localparam int LINE_OFFSET_BITS = 5;
  localparam int WB_LINE_BITS     = 256;
  localparam int WB_TAG_BITS      = 32 - LINE_OFFSET_BITS;

  typedef struct packed {
    logic [31:0]      address;
    logic [7:0][31:0] words;
  } wb_record_t;

  typedef enum logic [1:0] {
    WB_IDLE,
    WB_READ,
    WB_WRITE
  } wb_state_e;

endpackage

// File: rtl/data_cache_write_back_buffer_if.sv
// Cache-side and memory-control signals of the write-back buffer.
// Names are from the buffer's point of view: i_* flow into it, o_* flow out.
interface data_cache_write_back_buffer_if #(
  parameter int LINE_BITS = 256
);

  logic                 i_wb_push;
  logic [31:0]          i_wb_address;
  logic [LINE_BITS-1:0] i_wb_line;
  logic                 o_wb_full;

  logic                 i_fill_req;
  logic [31:0]          i_fill_address;
  logic                 o_fill_valid;
  logic [LINE_BITS-1:0] o_fill_line;

  logic                 i_mem_ready;
  logic                 i_mem_done;
  logic [31:0]          o_mem_address;
  logic                 o_mem_read;
  logic                 o_mem_write;

  modport slave (
    input  i_wb_push, i_wb_address, i_wb_line,
    input  i_fill_req, i_fill_address,
    input  i_mem_ready, i_mem_done,
    output o_wb_full, o_fill_valid, o_fill_line,
    output o_mem_address, o_mem_read, o_mem_write
  );

  modport master (
    output i_wb_push, i_wb_address, i_wb_line,
    output i_fill_req, i_fill_address,
    output i_mem_ready, i_mem_done,
    input  o_wb_full, o_fill_valid, o_fill_line,
    input  o_mem_address, o_mem_read, o_mem_write
  );

endinterface

// File: rtl/data_cache_write_back_buffer_wb_line_queue.sv
// Circular queue of evicted lines with an associative address match used
// both for coalescing pushes and for serving fills out of pending write-backs.
module data_cache_write_back_buffer_wb_line_queue
  import data_cache_write_back_buffer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    push,
  input  wb_record_t              push_record,
  input  logic                    pop,
  input  logic                    protect_head,
  input  logic [WB_TAG_BITS-1:0]  lookup_tag,
  output logic                    full,
  output logic                    empty,
  output wb_record_t              head,
  output logic                    lookup_hit,
  output logic [WB_LINE_BITS-1:0] lookup_line
);

  localparam int IDX_W = $clog2(DEPTH);

  typedef logic [IDX_W:0]   ptr_t;
  typedef logic [IDX_W-1:0] idx_t;

  ptr_t       wr_ptr;
  ptr_t       rd_ptr;
  ptr_t       count;
  idx_t       wr_idx;
  idx_t       rd_idx;
  idx_t       age_idx [DEPTH];
  wb_record_t entries [DEPTH];

  logic       accept;
  logic       coalesce;
  idx_t       coalesce_idx;

  assign wr_idx = wr_ptr[IDX_W-1:0];
  assign rd_idx = rd_ptr[IDX_W-1:0];
  assign count  = wr_ptr - rd_ptr;
  assign empty  = (wr_ptr == rd_ptr);
  assign full   = (wr_idx == rd_idx) && (wr_ptr[IDX_W] != rd_ptr[IDX_W]);
  assign head   = entries[rd_idx];
  assign accept = push && !full;

  // Slot holding the k-th oldest entry; index arithmetic wraps modulo DEPTH.
  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      age_idx[k] = rd_idx + idx_t'(k);
    end
  end

  // Walk oldest to youngest so the youngest copy of a line wins. A duplicate
  // can only exist while the head is being written and a newer copy appended.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the loop can leave one unassigned and infer a latch.
    coalesce     = 1'b0;
    coalesce_idx = '0;
    lookup_hit   = 1'b0;
    lookup_line  = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (ptr_t'(k) < count) begin
        if (entries[age_idx[k]].address[31:LINE_OFFSET_BITS] ==
              push_record.address[31:LINE_OFFSET_BITS] &&
            !(protect_head && k == 0)) begin
          coalesce     = 1'b1;
          coalesce_idx = age_idx[k];
        end
        if (entries[age_idx[k]].address[31:LINE_OFFSET_BITS] == lookup_tag) begin
          lookup_hit  = 1'b1;
          lookup_line = entries[age_idx[k]].words;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    // NOTE: clocked state is updated with non-blocking assignments only, so
    // every read in this block sees the pre-edge value.
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (accept && !coalesce) wr_ptr <= wr_ptr + ptr_t'(1);
      if (pop && !empty)       rd_ptr <= rd_ptr + ptr_t'(1);
    end
  end

  // NOTE: the line storage is deliberately not reset; an entry is only
  // meaningful between the pointers, and those are reset.
  always_ff @(posedge clock) begin
    if (accept) begin
      if (coalesce) entries[coalesce_idx].words <= push_record.words;
      else          entries[wr_idx]             <= push_record;
    end
  end

endmodule

// File: rtl/data_cache_write_back_buffer.sv
// Write-back buffer between DataCache and the 256-bit memory port: drains
// evicted lines in the background, serves fills first, forwarding queued data.
module data_cache_write_back_buffer
  import data_cache_write_back_buffer_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int LINE_BITS = WB_LINE_BITS
) (
  input  logic                           clock,
  input  logic                           reset,
  data_cache_write_back_buffer_if.slave  bus,
  inout  wire  [LINE_BITS-1:0]           io_mem_data
);

  wb_state_e             state;
  wb_state_e             state_next;

  wb_record_t            push_record;
  wb_record_t            head;
  logic                  q_full;
  logic                  q_empty;
  logic                  q_hit;
  logic [LINE_BITS-1:0]  q_line;
  logic                  pop;

  logic                  fill_pending;
  logic                  push_hit;
  logic                  fill_hit;
  logic [LINE_BITS-1:0]  hit_line;

  logic [31:0]           fill_address_q;
  logic                  fill_valid_q;
  logic [LINE_BITS-1:0]  fill_line_q;

  logic                  mem_read;
  logic                  mem_write;
  logic [31:0]           mem_address;

  // The byte offset within a line carries no information here.
  logic                  unused_offset_bits;
  assign unused_offset_bits = ^{bus.i_wb_address[LINE_OFFSET_BITS-1:0],
                                bus.i_fill_address[LINE_OFFSET_BITS-1:0]};

  assign push_record = '{address: {bus.i_wb_address[31:LINE_OFFSET_BITS], {LINE_OFFSET_BITS{1'b0}}},
                         words:   bus.i_wb_line};

  data_cache_write_back_buffer_wb_line_queue #(
    .DEPTH (DEPTH)
  ) u_queue (
    .clock        (clock),
    .reset        (reset),
    .push         (bus.i_wb_push),
    .push_record  (push_record),
    .pop          (pop),
    .protect_head (state == WB_WRITE),
    .lookup_tag   (bus.i_fill_address[31:LINE_OFFSET_BITS]),
    .full         (q_full),
    .empty        (q_empty),
    .head         (head),
    .lookup_hit   (q_hit),
    .lookup_line  (q_line)
  );

  // The requester still holds i_fill_req during the o_fill_valid cycle.
  assign fill_pending = bus.i_fill_req && !fill_valid_q;
  assign push_hit     = bus.i_wb_push && !q_full &&
                        (bus.i_wb_address[31:LINE_OFFSET_BITS] ==
                         bus.i_fill_address[31:LINE_OFFSET_BITS]);
  assign fill_hit     = push_hit || q_hit;
  assign hit_line     = push_hit ? bus.i_wb_line : q_line;
  assign pop          = (state == WB_WRITE) && bus.i_mem_done;

  always_ff @(posedge clock) begin
    if (reset) state <= WB_IDLE;
    else       state <= state_next;
  end

  // A missing fill beats draining, but never interrupts a write in flight.
  always_comb begin
    state_next = state;
    unique case (state)
      WB_IDLE: begin
        if (fill_pending && !fill_hit) state_next = WB_READ;
        else if (!q_empty)             state_next = WB_WRITE;
      end
      WB_READ:  if (bus.i_mem_ready) state_next = WB_IDLE;
      WB_WRITE: if (bus.i_mem_done)  state_next = WB_IDLE;
      default:                       state_next = WB_IDLE;
    endcase
  end

  // The head cannot move while WRITE, so its address and line stay stable.
  always_comb begin
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    mem_address = '0;
    unique case (state)
      WB_READ: begin
        mem_read    = 1'b1;
        mem_address = fill_address_q;
      end
      WB_WRITE: begin
        mem_write   = 1'b1;
        mem_address = head.address;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      fill_address_q <= '0;
      fill_valid_q   <= 1'b0;
      fill_line_q    <= '0;
    end else begin
      fill_valid_q <= 1'b0;
      if (state == WB_IDLE && fill_pending) begin
        if (fill_hit) begin
          fill_valid_q <= 1'b1;
          fill_line_q  <= hit_line;
        end else begin
          fill_address_q <= {bus.i_fill_address[31:LINE_OFFSET_BITS], {LINE_OFFSET_BITS{1'b0}}};
        end
      end
      if (state == WB_READ && bus.i_mem_ready) begin
        fill_valid_q <= 1'b1;
        fill_line_q  <= io_mem_data;
      end
    end
  end

  assign io_mem_data       = mem_write ? head.words : 'z;

  assign bus.o_wb_full     = q_full;
  assign bus.o_fill_valid  = fill_valid_q;
  assign bus.o_fill_line   = fill_line_q;
  assign bus.o_mem_address = mem_address;
  assign bus.o_mem_read    = mem_read;
  assign bus.o_mem_write   = mem_write;

endmodule

// File: tb/tb_data_cache_write_back_buffer.sv
// Directed bench for the write-back buffer: stimulus queues expected memory
// writes, reads and fill returns; a negedge monitor pops and compares them.
module tb_data_cache_write_back_buffer;

  typedef struct {
    logic [31:0]  addr;
    logic [255:0] line;
  } wr_exp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  data_cache_write_back_buffer_if bus ();

  logic         mem_drive = 1'b0;
  logic [255:0] mem_val   = '0;
  wire  [255:0] mem_data;
  assign mem_data = mem_drive ? mem_val : 'z;

  data_cache_write_back_buffer #(
    .DEPTH     (4),
    .LINE_BITS (256)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .bus         (bus),
    .io_mem_data (mem_data)
  );

  int checks = 0;
  int errors = 0;

  wr_exp_t      exp_wr   [$];
  logic [31:0]  exp_rd   [$];
  logic [255:0] exp_fill [$];

  task automatic check(input string name, input logic [255:0] actual, input logic [255:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, actual, expected);
    end
  endtask

  function automatic logic [255:0] rep8(input logic [31:0] w);
    return {8{w}};
  endfunction

  // Monitor: every new memory write/read and every fill pulse consumes one expectation.
  logic prev_write = 1'b0;
  logic prev_read  = 1'b0;
  always @(negedge clock) begin
    wr_exp_t      w;
    logic [31:0]  ra;
    logic [255:0] fl;
    if (bus.o_mem_write && !prev_write) begin
      if (exp_wr.size() == 0) begin
        check("write_unexpected", 256'(bus.o_mem_write), 256'(0));
      end else begin
        w = exp_wr.pop_front();
        check("write_addr", 256'(bus.o_mem_address), 256'(w.addr));
        check("write_data", mem_data, w.line);
      end
    end
    if (bus.o_mem_read && !prev_read) begin
      if (exp_rd.size() == 0) begin
        check("read_unexpected", 256'(bus.o_mem_read), 256'(0));
      end else begin
        ra = exp_rd.pop_front();
        check("read_addr", 256'(bus.o_mem_address), 256'(ra));
      end
    end
    if (bus.o_fill_valid) begin
      if (exp_fill.size() == 0) begin
        check("fill_unexpected", 256'(bus.o_fill_valid), 256'(0));
      end else begin
        fl = exp_fill.pop_front();
        check("fill_line", bus.o_fill_line, fl);
      end
    end
    prev_write = bus.o_mem_write;
    prev_read  = bus.o_mem_read;
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input logic [31:0] a, input logic [255:0] l);
    bus.i_wb_push    = 1'b1;
    bus.i_wb_address = a;
    bus.i_wb_line    = l;
    step();
    bus.i_wb_push    = 1'b0;
  endtask

  task automatic wait_write();
    int n = 0;
    while (!bus.o_mem_write && n < 50) begin
      step();
      n++;
    end
    check("wait_write_timeout", 256'(bus.o_mem_write), 256'(1));
  endtask

  task automatic wait_read();
    int n = 0;
    while (!bus.o_mem_read && n < 50) begin
      step();
      n++;
    end
    check("wait_read_timeout", 256'(bus.o_mem_read), 256'(1));
  endtask

  task automatic wait_fill();
    int n = 0;
    while (!bus.o_fill_valid && n < 50) begin
      step();
      n++;
    end
    check("wait_fill_timeout", 256'(bus.o_fill_valid), 256'(1));
    bus.i_fill_req = 1'b0;
  endtask

  task automatic mem_done_pulse();
    wait_write();
    bus.i_mem_done = 1'b1;
    step();
    bus.i_mem_done = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=still_running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic activity;
    bus.i_wb_push      = 1'b0;
    bus.i_wb_address   = '0;
    bus.i_wb_line      = '0;
    bus.i_fill_req     = 1'b0;
    bus.i_fill_address = '0;
    bus.i_mem_ready    = 1'b0;
    bus.i_mem_done     = 1'b0;

    reset = 1'b1;
    repeat (3) step();
    reset = 1'b0;
    step();
    check("rst_full",       256'(bus.o_wb_full),     256'(0));
    check("rst_fill_valid", 256'(bus.o_fill_valid),  256'(0));
    check("rst_fill_line",  bus.o_fill_line,         256'(0));
    check("rst_mem_read",   256'(bus.o_mem_read),    256'(0));
    check("rst_mem_write",  256'(bus.o_mem_write),   256'(0));
    check("rst_mem_addr",   256'(bus.o_mem_address), 256'(0));

    // Reset in the middle of a write abandons it.
    exp_wr.push_back('{32'h0000_0100, rep8(32'h1111_0100)});
    push(32'h0000_0100, rep8(32'h1111_0100));
    wait_write();
    step();
    reset = 1'b1;
    step();
    check("midrst_mem_write", 256'(bus.o_mem_write),   256'(0));
    check("midrst_mem_read",  256'(bus.o_mem_read),    256'(0));
    check("midrst_mem_addr",  256'(bus.o_mem_address), 256'(0));
    check("midrst_full",      256'(bus.o_wb_full),     256'(0));
    check("midrst_fill",      256'(bus.o_fill_valid),  256'(0));
    mem_val   = rep8(32'h5A5A_A5A5);
    mem_drive = 1'b1;
    #1;
    check("midrst_bus_released", mem_data, rep8(32'h5A5A_A5A5));
    mem_drive = 1'b0;
    reset = 1'b0;
    activity = 1'b0;
    repeat (6) begin
      step();
      activity = activity | bus.o_mem_write | bus.o_mem_read;
    end
    check("post_reset_quiet", 256'(activity), 256'(0));

    // Fill the queue with memory stalled; a fifth push is dropped.
    exp_wr.push_back('{32'h0000_0000, rep8(32'h2222_0000)});
    exp_wr.push_back('{32'h0000_0020, rep8(32'h2222_0020)});
    exp_wr.push_back('{32'h0000_0040, rep8(32'h2222_0040)});
    exp_wr.push_back('{32'h0000_0060, rep8(32'h2222_0060)});
    push(32'h0000_0000, rep8(32'h2222_0000));
    push(32'h0000_0020, rep8(32'h2222_0020));
    push(32'h0000_0040, rep8(32'h2222_0040));
    push(32'h0000_0060, rep8(32'h2222_0060));
    check("full_after_4", 256'(bus.o_wb_full), 256'(1));
    push(32'h0000_00A0, rep8(32'h2222_00A0));
    check("full_after_dropped_push", 256'(bus.o_wb_full), 256'(1));

    // Fill hit on a queued line is served from the queue once WRITE ends.
    exp_fill.push_back(rep8(32'h2222_0040));
    bus.i_fill_address = 32'h0000_0040;
    bus.i_fill_req     = 1'b1;
    mem_done_pulse();
    check("full_after_pop", 256'(bus.o_wb_full), 256'(0));
    wait_fill();
    check("hit_no_read", 256'(bus.o_mem_read), 256'(0));
    repeat (3) mem_done_pulse();

    // Coalescing behind a busy head; a push to the head's own line appends.
    exp_wr.push_back('{32'h0000_00C0, rep8(32'h3333_00C0)});
    exp_wr.push_back('{32'h0000_0080, rep8(32'hBBBB_BBBB)});
    exp_wr.push_back('{32'h0000_00C0, rep8(32'hDDDD_DDDD)});
    push(32'h0000_00C0, rep8(32'h3333_00C0));
    wait_write();
    push(32'h0000_0080, rep8(32'hAAAA_AAAA));
    push(32'h0000_0080, rep8(32'hBBBB_BBBB));
    push(32'h0000_00C0, rep8(32'hDDDD_DDDD));
    check("coalesce_not_full", 256'(bus.o_wb_full), 256'(0));
    repeat (3) mem_done_pulse();

    // Miss waits for the in-flight write, then reads before the queue drains.
    exp_wr.push_back('{32'h0000_00E0, rep8(32'h4444_00E0)});
    exp_wr.push_back('{32'h0000_0120, rep8(32'h4444_0120)});
    push(32'h0000_00E0, rep8(32'h4444_00E0));
    push(32'h0000_0120, rep8(32'h4444_0120));
    wait_write();
    exp_rd.push_back(32'h0000_0200);
    exp_fill.push_back(rep8(32'hDEAD_BEEF));
    bus.i_fill_address = 32'h0000_0200;
    bus.i_fill_req     = 1'b1;
    repeat (3) step();
    check("miss_waits_read",  256'(bus.o_mem_read),  256'(0));
    check("miss_write_held",  256'(bus.o_mem_write), 256'(1));
    mem_done_pulse();
    wait_read();
    mem_val         = rep8(32'hDEAD_BEEF);
    mem_drive       = 1'b1;
    bus.i_mem_ready = 1'b1;
    step();
    bus.i_mem_ready = 1'b0;
    mem_drive       = 1'b0;
    wait_fill();
    mem_done_pulse();

    // Same-cycle push and fill of one line; offset bits are ignored.
    exp_fill.push_back(rep8(32'hCCCC_CCCC));
    exp_wr.push_back('{32'h0000_0300, rep8(32'hCCCC_CCCC)});
    bus.i_fill_address = 32'h0000_0304;
    bus.i_fill_req     = 1'b1;
    push(32'h0000_031C, rep8(32'hCCCC_CCCC));
    wait_fill();
    check("push_hit_no_read", 256'(bus.o_mem_read), 256'(0));
    mem_done_pulse();

    repeat (4) step();
    check("writes_drained", 256'(exp_wr.size()),   256'(0));
    check("reads_drained",  256'(exp_rd.size()),   256'(0));
    check("fills_drained",  256'(exp_fill.size()), 256'(0));
    check("final_idle",     256'(bus.o_mem_write), 256'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
